stoch_mult_acc: RTL and testbench

STOCH_MULT_ACC -- requirements
Module: stoch_mult_acc

---
 rtl/stoch_pkg.sv | 10 +
 rtl/stoch_prod.sv | 23 ++
 rtl/stoch_mult_acc.sv | 69 ++++++
 tb/tb_stoch_mult_acc.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/stoch_pkg.sv
// Shared stochastic-computing definitions: product modes and the count-width rule.
package stoch_pkg;
  localparam int MODE_UNIPOLAR = 0;
  localparam int MODE_BIPOLAR  = 1;

  // A window of 2^w samples can hold 2^w ones, so the count needs one extra bit.
  function automatic int cnt_w(input int w);
    return w + 1;
  endfunction
endpackage

// File: rtl/stoch_prod.sv
// N-input stochastic product: AND for unipolar streams, chained XNOR for bipolar streams.
module stoch_prod
  import stoch_pkg::*;
#(
  parameter int N    = 3,
  parameter int MODE = MODE_UNIPOLAR
) (
  input  logic [N-1:0] i_in,
  output logic         o_p
);
  generate
    if (MODE == MODE_BIPOLAR) begin : g_xnor
      logic w_chain;
      always_comb begin
        w_chain = i_in[0];
        for (int i = 1; i < N; i++) w_chain = ~(w_chain ^ i_in[i]);
      end
      assign o_p = w_chain;
    end else begin : g_and
      assign o_p = &i_in;
    end
  endgenerate
endmodule

// File: rtl/stoch_mult_acc.sv
// Stochastic multiplier with a windowed ones-counter: registers the product stream and
// reports the number of ones seen in each 2^W-sample enabled window.
module stoch_mult_acc
  import stoch_pkg::*;
#(
  parameter int N    = 3,
  parameter int MODE = MODE_UNIPOLAR,
  parameter int W    = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic                  CLR,
  input  logic [N-1:0]          IN,
  output logic                  OUT,
  output logic [cnt_w(W)-1:0]   COUNT,
  output logic                  VALID
);
  localparam int CW = cnt_w(W);

  logic          w_p;
  logic [CW-1:0] w_acc_next;
  logic [W-1:0]  r_wcnt;
  logic [CW-1:0] r_acc;
  logic [CW-1:0] r_count;
  logic          r_out;
  logic          r_valid;

  stoch_prod #(.N(N), .MODE(MODE)) u_prod (
    .i_in (IN),
    .o_p  (w_p)
  );

  assign w_acc_next = r_acc + {{(CW-1){1'b0}}, w_p};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wcnt  <= '0;
      r_acc   <= '0;
      r_count <= '0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
    end else if (CLR) begin
      // Restart wins over a coincident window end; COUNT keeps the last result.
      r_wcnt  <= '0;
      r_acc   <= '0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_out   <= EN & w_p;
      r_valid <= 1'b0;
      if (EN) begin
        if (r_wcnt == {W{1'b1}}) begin
          r_count <= w_acc_next;
          r_valid <= 1'b1;
          r_acc   <= '0;
          r_wcnt  <= '0;
        end else begin
          r_acc   <= w_acc_next;
          r_wcnt  <= r_wcnt + 1'b1;
        end
      end
    end
  end

  assign OUT   = r_out;
  assign COUNT = r_count;
  assign VALID = r_valid;
endmodule

// File: tb/tb_stoch_mult_acc.sv
// Directed bench: unipolar N=3 and bipolar N=2 instances, both W=4, sharing control inputs.
module tb_stoch_mult_acc;
  import stoch_pkg::*;

  logic       CLK, RST_N, EN, CLR;
  logic [2:0] in3;
  logic [1:0] in2;
  logic       out3, out2, valid3, valid2;
  logic [4:0] count3, count2;
  int checks = 0;
  int errors = 0;

  stoch_mult_acc #(.N(3), .MODE(MODE_UNIPOLAR), .W(4)) dut_u (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR(CLR), .IN(in3),
    .OUT(out3), .COUNT(count3), .VALID(valid3)
  );

  stoch_mult_acc #(.N(2), .MODE(MODE_BIPOLAR), .W(4)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR(CLR), .IN(in2),
    .OUT(out2), .COUNT(count2), .VALID(valid2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; EN = 1'b0; CLR = 1'b0; in3 = 3'b111; in2 = 2'b11;
    tick; tick;
    checks++;
    if (out3 !== 1'b0 || valid3 !== 1'b0 || count3 !== 5'd0) begin
      errors++;
      $display("FAIL reset_u: out=%b valid=%b count=%0d required 0 0 0", out3, valid3, count3);
    end
    checks++;
    if (out2 !== 1'b0 || valid2 !== 1'b0 || count2 !== 5'd0) begin
      errors++;
      $display("FAIL reset_b: out=%b valid=%b count=%0d required 0 0 0", out2, valid2, count2);
    end
  endtask

  // Two back-to-back all-ones windows starting right at reset release.
  task automatic test_full_window;
    RST_N = 1'b1; EN = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick;
      checks++;
      if (out3 !== 1'b1) begin
        errors++;
        $display("FAIL full_out edge %0d: got %b required 1", i, out3);
      end
      checks++;
      if (valid3 !== (i % 16 == 0)) begin
        errors++;
        $display("FAIL full_valid edge %0d: got %b required %b", i, valid3, (i % 16 == 0));
      end
      if (i % 16 == 0) begin
        checks++;
        if (count3 !== 5'd16 || count2 !== 5'd16) begin
          errors++;
          $display("FAIL full_count edge %0d: got %0d/%0d required 16/16", i, count3, count2);
        end
      end
    end
  endtask

  task automatic test_toggle;
    in2 = 2'b01;
    for (int i = 0; i < 16; i++) begin
      in3 = {2'b11, (i % 2 == 0)};
      tick;
      checks++;
      if (out3 !== (i % 2 == 0)) begin
        errors++;
        $display("FAIL toggle_out sample %0d: got %b required %b", i, out3, (i % 2 == 0));
      end
    end
    checks++;
    if (valid3 !== 1'b1 || count3 !== 5'd8) begin
      errors++;
      $display("FAIL toggle_count: valid=%b count=%0d required 1 8", valid3, count3);
    end
    checks++;
    if (valid2 !== 1'b1 || count2 !== 5'd0) begin
      errors++;
      $display("FAIL bipolar_01: valid=%b count=%0d required 1 0", valid2, count2);
    end
  endtask

  task automatic test_bipolar;
    in2 = 2'b00; in3 = 3'b101;
    for (int i = 0; i < 16; i++) tick;
    checks++;
    if (valid2 !== 1'b1 || count2 !== 5'd16) begin
      errors++;
      $display("FAIL bipolar_00: valid=%b count=%0d required 1 16", valid2, count2);
    end
    checks++;
    if (count3 !== 5'd0 || out3 !== 1'b0) begin
      errors++;
      $display("FAIL unipolar_zero: count=%0d out=%b required 0 0", count3, out3);
    end
  endtask

  // Samples 0..5 enabled, 5-cycle gap, then samples 6..15: VALID lands on edge 21.
  task automatic test_en_gap;
    in3 = 3'b111;
    for (int i = 1; i <= 21; i++) begin
      EN = !(i >= 7 && i <= 11);
      tick;
      if (!EN) begin
        checks++;
        if (out3 !== 1'b0) begin
          errors++;
          $display("FAIL gap_out edge %0d: got %b required 0", i, out3);
        end
      end
      checks++;
      if (valid3 !== (i == 21)) begin
        errors++;
        $display("FAIL gap_valid edge %0d: got %b required %b", i, valid3, (i == 21));
      end
    end
    EN = 1'b1;
    checks++;
    if (count3 !== 5'd16) begin
      errors++;
      $display("FAIL gap_count: got %0d required 16", count3);
    end
  endtask

  // CLR at sample 10; new window has 12 ones then 4 zeros.
  task automatic test_clr;
    in3 = 3'b111;
    for (int i = 0; i < 10; i++) tick;
    CLR = 1'b1;
    tick;
    CLR = 1'b0;
    checks++;
    if (out3 !== 1'b0 || valid3 !== 1'b0 || count3 !== 5'd16) begin
      errors++;
      $display("FAIL clr_edge: out=%b valid=%b count=%0d required 0 0 16", out3, valid3, count3);
    end
    for (int i = 1; i <= 16; i++) begin
      in3 = (i <= 12) ? 3'b111 : 3'b011;
      tick;
      checks++;
      if (valid3 !== (i == 16)) begin
        errors++;
        $display("FAIL clr_valid edge %0d: got %b required %b", i, valid3, (i == 16));
      end
      if (i < 16) begin
        checks++;
        if (count3 !== 5'd16) begin
          errors++;
          $display("FAIL clr_hold edge %0d: got %0d required 16", i, count3);
        end
      end
    end
    checks++;
    if (count3 !== 5'd12) begin
      errors++;
      $display("FAIL clr_count: got %0d required 12", count3);
    end
  endtask

  task automatic test_reset_mid;
    in3 = 3'b111;
    for (int i = 0; i < 7; i++) tick;
    RST_N = 1'b0;
    #1;
    checks++;
    if (out3 !== 1'b0 || valid3 !== 1'b0 || count3 !== 5'd0) begin
      errors++;
      $display("FAIL rst_mid: out=%b valid=%b count=%0d required 0 0 0", out3, valid3, count3);
    end
    #1;
    RST_N = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick;
      checks++;
      if (valid3 !== (i == 16)) begin
        errors++;
        $display("FAIL rst_valid edge %0d: got %b required %b", i, valid3, (i == 16));
      end
    end
    checks++;
    if (count3 !== 5'd16) begin
      errors++;
      $display("FAIL rst_count: got %0d required 16", count3);
    end
  endtask

  initial begin
    test_reset;
    test_full_window;
    test_toggle;
    test_bipolar;
    test_en_gap;
    test_clr;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
